mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8x8 shift-add multiplier among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and starts the multiplier by pulsing its active-high reset. It captures the 16-bit product on the multiplier's end-of-operation flag and returns it to the granted requester. It sits between the requesting blocks and the single multiplier instance.

---
 rtl/mult_share_arbiter.sv | 136 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one shift-add 8x8 multiplier
// Optional watchdog built when MULT_SHARE_ARBITER_TIMEOUT_EN is defined.
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 mul_rst,
  output logic [7:0]           mul_multiplicand,
  output logic [7:0]           mul_multiplier,
  input  logic [15:0]          mul_result,
  input  logic                 mul_end_op,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [2:0] LAST   = 3'(NREQ - 1);

  // Parameter range guard; an out-of-range setting leaves this marker block in the hierarchy.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_out_of_range
  end

  logic [1:0]  state;
  logic [2:0]  ptr;
  logic [7:0]  valid_pad;
  logic [7:0]  rsp_ready_pad;
  logic [63:0] a_pad;
  logic [63:0] b_pad;
  logic        gnt_found;
  logic [2:0]  gnt_idx;
  logic [3:0]  cand;
  logic        grant;
  logic        take_rsp;
  logic        wd_fire;

  assign valid_pad     = 8'(req_valid);
  assign rsp_ready_pad = 8'(rsp_ready);
  assign a_pad         = 64'(req_a);
  assign b_pad         = 64'(req_b);

  // First pending requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!gnt_found && valid_pad[cand[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[2:0];
      end
    end
  end

  assign grant    = (state == S_IDLE) && gnt_found;
  assign take_rsp = (state == S_RESP) && rsp_ready_pad[grant_id];
  assign mul_rst  = (state != S_RUN);
  assign busy     = (state != S_IDLE);

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (gnt_idx == 3'(i));
      rsp_valid[i] = (state == S_RESP) && (grant_id == 3'(i));
    end
  end

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
  logic [7:0] wd;

  assign wd_fire = (wd == 8'(TIMEOUT - 1));

  // A product arriving on the firing cycle takes precedence over the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd      <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == S_IDLE) wd <= '0;
      else if (state == S_RUN && !mul_end_op && !wd_fire) wd <= wd + 8'd1;
      if (state == S_RUN && mul_end_op) rsp_err <= 1'b0;
      else if (state == S_RUN && wd_fire) rsp_err <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      ptr              <= '0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      rsp_result       <= '0;
      grant_id         <= '0;
    end else begin
      case (state)
        S_IDLE: if (grant) begin
          mul_multiplicand <= a_pad[{gnt_idx, 3'b000} +: 8];
          mul_multiplier   <= b_pad[{gnt_idx, 3'b000} +: 8];
          grant_id         <= gnt_idx;
          state            <= S_RUN;
        end
        S_RUN: if (mul_end_op) begin
          rsp_result <= mul_result;
          state      <= S_RESP;
        end else if (wd_fire) begin
          rsp_result <= 16'h0000;
          state      <= S_RESP;
        end
        S_RESP: if (take_rsp) begin
          ptr   <= (grant_id == LAST) ? 3'd0 : grant_id + 3'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed and random checks of mult_share_arbiter
// Watchdog cases depend on MULT_SHARE_ARBITER_TIMEOUT_EN.
module tb_mult_share_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b;
  logic [15:0] rsp_result;
  logic        rsp_err, mul_rst, busy;
  logic [7:0]  mul_multiplicand, mul_multiplier;
  logic [15:0] mul_result = '0;
  logic        mul_end_op = 1'b0;
  logic [2:0]  grant_id;

  int n_asserts = 0;
  int n_fail    = 0;
  int mlat      = 4;
  bit hang      = 1'b0;
  int m_cnt     = 0;
  int ptr_m     = 0;

  mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .mul_rst(mul_rst), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_result(mul_result), .mul_end_op(mul_end_op),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product appears mlat cycles after its reset is released.
  always @(posedge clk) begin
    if (mul_rst) begin
      m_cnt      <= 0;
      mul_end_op <= 1'b0;
      mul_result <= '0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (!hang && m_cnt == mlat - 1) begin
        mul_end_op <= 1'b1;
        mul_result <= 16'(mul_multiplicand) * 16'(mul_multiplier);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] pend, input int p);
    for (int k = 0; k < NREQ; k++)
      if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (req_ready == 0 && n < 100) begin @(negedge clk); #1; n++; end
    chk("grant_wait", 32'(req_ready != 0), 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (rsp_valid == 0 && n < 300) begin @(negedge clk); #1; n++; end
  endtask

  // Called in the cycle the grant to id is visible; completes that operation.
  task automatic finish_txn(input int id, input logic [7:0] a, input logic [7:0] b, input int l);
    int n;
    logic [15:0] exp;
    exp = a * b;
    @(negedge clk); req_valid[id] = 1'b0; #1;
    chk("ready_pulse", req_ready, 0);
    chk("mul_rst_run", mul_rst, 0);
    chk("operand_a", mul_multiplicand, a);
    chk("operand_b", mul_multiplier, b);
    chk("grant_id", grant_id, id);
    wait_rsp(n);
    if (l >= 0) chk("latency", n, l + 2);
    chk("rsp_valid", rsp_valid, 32'd1 << id);
    chk("rsp_result", rsp_result, exp);
    chk("rsp_err", rsp_err, 0);
    @(negedge clk); #1;
    chk("rsp_done", rsp_valid, 0);
    ptr_m = (id + 1) % NREQ;
  endtask

  task automatic run_txn(input int id, input logic [7:0] a, input logic [7:0] b, input int l);
    mlat = l;
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_valid[id] = 1'b1;
    #1;
    wait_ready();
    chk("grant", req_ready, 32'd1 << id);
    finish_txn(id, a, b, l);
  endtask

  initial begin
    logic [7:0] ra [4];
    logic [7:0] rb [4];
    logic [3:0] pend;
    int e, n;
    bit reraised;

    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mul_rst", mul_rst, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_operands", {mul_multiplicand, mul_multiplier}, 0);
    chk("rst_result", {rsp_err, rsp_result}, 0);
    chk("rst_grant_id", grant_id, 0);
    @(negedge clk); rst = 1'b1; #1;

    run_txn(0, 8'd13, 8'd11, 6);
    chk("first_product", rsp_result, 16'h008F);
    run_txn(2, 8'd255, 8'd255, 3);
    chk("max_product", rsp_result, 16'hFE01);
    run_txn(2, 8'd0, 8'd200, 9);
    run_txn(3, 8'($urandom), 8'($urandom), 2);

    // All four pending, then requester 0 re-raised after its response.
    pend = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 8'($urandom); rb[i] = 8'($urandom);
      req_a[8*i +: 8] = ra[i]; req_b[8*i +: 8] = rb[i];
    end
    req_valid = pend; mlat = 5; reraised = 1'b0;
    for (int g = 0; g < 5; g++) begin
      #1;
      wait_ready();
      e = rr_pick(pend, ptr_m);
      chk("rr_grant", req_ready, 32'd1 << e);
      pend[e] = 1'b0;
      finish_txn(e, ra[e], rb[e], 5);
      if (e == 0 && !reraised) begin
        reraised = 1'b1;
        ra[0] = 8'($urandom); rb[0] = 8'($urandom);
        req_a[7:0] = ra[0]; req_b[7:0] = rb[0];
        pend[0] = 1'b1; req_valid[0] = 1'b1;
      end
    end

    // Response backpressure on requester 1 while requester 2 waits.
    ra[1] = 8'($urandom); rb[1] = 8'($urandom); ra[2] = 8'($urandom); rb[2] = 8'($urandom);
    req_a[15:8] = ra[1]; req_b[15:8] = rb[1]; req_a[23:16] = ra[2]; req_b[23:16] = rb[2];
    req_valid = 4'b0110; rsp_ready = 4'b1101; mlat = 4; #1;
    wait_ready();
    chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk); req_valid[1] = 1'b0; #1;
    wait_rsp(n);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", rsp_valid, 4'b0010);
      chk("bp_hold_result", rsp_result, ra[1] * rb[1]);
      chk("bp_no_grant", req_ready, 0);
      @(negedge clk); #1;
    end
    rsp_ready = 4'b1111;
    @(negedge clk); #1;
    chk("bp_released", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0100);
    finish_txn(2, ra[2], rb[2], 4);

    // Reset in the middle of RUN; stale ptr would favour requester 3 over 1.
    mlat = 10; req_valid[2] = 1'b1; #1;
    wait_ready();
    chk("rst_run_grant", req_ready, 4'b0100);
    @(negedge clk); req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    chk("midrun_busy", busy, 0);
    chk("midrun_mul_rst", mul_rst, 1);
    chk("midrun_rsp_valid", rsp_valid, 0);
    chk("midrun_grant_id", grant_id, 0);
    @(negedge clk); rst = 1'b1; ptr_m = 0; #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    ra[3] = 8'($urandom); rb[3] = 8'($urandom); req_a[31:24] = ra[3]; req_b[31:24] = rb[3];
    req_valid = 4'b1010; mlat = 3; #1;
    chk("ptr_reset_grant", req_ready, 32'd1 << rr_pick(4'b1010, ptr_m));
    finish_txn(1, ra[1], rb[1], 3);
    #1;
    wait_ready();
    chk("after_rst_grant3", req_ready, 4'b1000);
    finish_txn(3, ra[3], rb[3], 3);

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
    hang = 1'b1; req_valid[0] = 1'b1; #1;
    wait_ready();
    chk("wd_grant", req_ready, 4'b0001);
    @(negedge clk); req_valid[0] = 1'b0; #1;
    wait_rsp(n);
    chk("wd_latency", n, TIMEOUT + 1);
    chk("wd_rsp_valid", rsp_valid, 4'b0001);
    chk("wd_err", rsp_err, 1);
    chk("wd_result", rsp_result, 0);
    @(negedge clk); hang = 1'b0; ptr_m = 1; #1;
    chk("wd_done", rsp_valid, 0);
    run_txn(1, 8'($urandom), 8'($urandom), TIMEOUT - 1);
`else
    hang = 1'b1; req_valid[0] = 1'b1; #1;
    wait_ready();
    chk("hang_grant", req_ready, 4'b0001);
    @(negedge clk); req_valid[0] = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    chk("hang_busy", busy, 1);
    chk("hang_no_rsp", rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1; hang = 1'b0; ptr_m = 0; #1;
    chk("hang_recovered", busy, 0);
`endif

    for (int t = 0; t < 8; t++)
      run_txn($urandom_range(0, NREQ - 1), 8'($urandom), 8'($urandom), $urandom_range(1, 12));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
